fsm_table: RTL and testbench
============================

FSM_TABLE -- requirements
Module: fsm_table

Interface
REQ-001 Parameter STATE_W, default 3, state-code width in bits.
REQ-002 Parameter IN_W, default 1, input-symbol width in bits.
REQ-003 Parameter OUT_W, default 3, output-code width in bits.
REQ-004 Parameter CNT_W, default 8, step-counter width in bits.
REQ-005 Parameter RESET_STATE, default 3'd2, state code loaded on reset and on error recovery.
REQ-006 Parameter RESET_OUT, default 3'd2, output code loaded on reset and on error recovery.
REQ-007 Port clk  input  1  single clock; every register updates on the rising edge.
REQ-008 Port reset  input  1  synchronous, active-high reset.
REQ-009 Port a  input  IN_W  input symbol.
REQ-010 Port en  input  1  advance the machine one step this cycle.
REQ-011 Port prog_we  input  1  table write strobe.
REQ-012 Port prog_addr  input  STATE_W+IN_W  table entry index, formed as {symbol, state}.
REQ-013 Port prog_next  input  STATE_W  next-state field to write.
REQ-014 Port prog_out  input  OUT_W  output field to write.
REQ-015 Port saida  output  OUT_W  registered output code.
REQ-016 Port state  output  STATE_W  registered current state.
REQ-017 Port err  output  1  sticky flag: an unprogrammed entry was used.
REQ-018 Port steps  output  CNT_W  count of successful transitions, saturating.

Function
REQ-019 The table SHALL hold DEPTH = 2^(STATE_W+IN_W) entries, each {valid, next, out}.
REQ-020 Lookup address SHALL be {a, state}, i.e. a in the MSBs.
REQ-021 When prog_we=1, the entry at prog_addr SHALL become {1, prog_next, prog_out} at the next edge.
REQ-022 On en=1, prog_we=0 and a valid entry: state<=next, saida<=out and steps<=steps+1, saturating at 2^CNT_W-1.
REQ-023 On en=1, prog_we=0 and an invalid entry: state<=RESET_STATE, saida<=RESET_OUT and err<=1; steps SHALL be held.
REQ-024 When prog_we=1 and en=1 in the same cycle, the write SHALL win: state, saida and steps held.
REQ-025 A write to the entry currently addressed SHALL first be used at the next en cycle, never in the same cycle.
REQ-026 With en=0, state, saida, steps and err SHALL hold.
REQ-027 err SHALL clear only on reset.
REQ-028 Transition latency SHALL be exactly 1 cycle from an en sample to the updated state and saida; outputs SHALL have no combinational path from a or en.

Reset
REQ-029 On reset=1 at an edge: state=RESET_STATE, saida=RESET_OUT, err=0, steps=0, and every valid bit=0.
REQ-030 Table data fields SHALL NOT be cleared by reset; only the valid bits are cleared.
REQ-031 Reset SHALL take priority over prog_we and en in the same cycle.

Structure
REQ-032 Default widths, RESET_STATE, RESET_OUT and the entry-field layout SHALL live in shared package fsm_table_pkg.
REQ-033 Storage plus valid bits SHALL be one sub-module, fsm_table_mem: one write port and one asynchronous read port.
REQ-034 Control, counter and error logic SHALL stay in fsm_table.

Verification (defaults; codes q0=2, q1=6, q2=4, q3=7, q4=1)
REQ-035 Reset: reset=1 for one edge -> state=2, saida=2, err=0, steps=0.
REQ-036 Program 10 entries (2->4 for both a; 6->7; 4: a0->1, a1->6; 7: a0->4, a1->2; 1->6), out=next; then en=1, a=0 -> state 4,1,6,7,4,1; steps=6.
REQ-037 From state 4 with a=1, en=1 -> state 6,7,2,4,6; saida tracks state.
REQ-038 Leave entries for state 1 unprogrammed; from 4, a=0 -> state 1, next step -> state=2, saida=2, err=1, steps unchanged.
REQ-039 prog_we=1 and en=1 same cycle at state 7 -> state stays 7, steps unchanged, entry readable next cycle.
REQ-040 Reset mid-run at state 7 -> state=2, err=0, steps=0, all entries invalid (next en raises err); CNT_W=2 run of 5 steps -> steps=3.

Source files
------------

// File: rtl/fsm_table_pkg.sv
// fsm_table_pkg: shared defaults and entry-field layout for the programmable FSM table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Each table entry is {valid, next, out}. The valid bit lives apart from the data
// so reset can clear it without touching the data array; data is stored as
// {next, out} with next in the upper bits.
package fsm_table_pkg;

    localparam int DEF_STATE_W = 3;
    localparam int DEF_IN_W    = 1;
    localparam int DEF_OUT_W   = 3;
    localparam int DEF_CNT_W   = 8;

    localparam logic [DEF_STATE_W-1:0] DEF_RESET_STATE = 3'd2;
    localparam logic [DEF_OUT_W-1:0]   DEF_RESET_OUT   = 3'd2;

    // Entry layout at default widths; the storage keeps the same field order
    // generically as {next, out} plus a separate valid bit per entry.
    typedef struct packed {
        logic                   vld;
        logic [DEF_STATE_W-1:0] nxt;
        logic [DEF_OUT_W-1:0]   out;
    } entry_t;

endpackage

// File: rtl/fsm_table_mem.sv
// fsm_table_mem: transition-table storage with per-entry valid bits.
// Latency: write lands at the next edge; read is asynchronous (same cycle).
// Backpressure: none; a write is accepted every cycle it is strobed.
//
// Ports: clk_i, reset_i (sync, active-high, clears valid bits only),
//        we_i/waddr_i/wdat_i (write port), raddr_i -> rvld_o/rdat_o (read port).
module fsm_table_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdat_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic              rvld_o,
    output logic [DATA_W-1:0] rdat_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    // Reset wins over a simultaneous write, so the written entry stays invalid.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_q <= '0;
        end else if (we_i) begin
            vld_q[waddr_i] <= 1'b1;
        end
    end

    // Data array carries no reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (we_i && !reset_i) begin
            dat_q[waddr_i] <= wdat_i;
        end
    end

    assign rvld_o = vld_q[raddr_i];
    assign rdat_o = dat_q[raddr_i];

endmodule

// File: rtl/fsm_table.sv
// fsm_table: table-driven Moore machine; state/saida advance by table lookup on en.
// Latency: 1 cycle from en sample to updated state/saida; all outputs registered.
// Backpressure: none; a table write in the same cycle as en suppresses the step.
//
// Ports: clk, reset (sync, active-high), a (input symbol), en (step strobe),
//        prog_we/prog_addr/prog_next/prog_out (table write, addr = {symbol, state}),
//        saida (output code), state (current state), err (sticky miss flag),
//        steps (saturating count of successful transitions).
module fsm_table
    import fsm_table_pkg::*;
#(
    parameter int                 STATE_W     = DEF_STATE_W,
    parameter int                 IN_W        = DEF_IN_W,
    parameter int                 OUT_W       = DEF_OUT_W,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(DEF_RESET_STATE),
    parameter logic [OUT_W-1:0]   RESET_OUT   = OUT_W'(DEF_RESET_OUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_W-1:0]         a,
    input  logic                    en,
    input  logic                    prog_we,
    input  logic [STATE_W+IN_W-1:0] prog_addr,
    input  logic [STATE_W-1:0]      prog_next,
    input  logic [OUT_W-1:0]        prog_out,
    output logic [OUT_W-1:0]        saida,
    output logic [STATE_W-1:0]      state,
    output logic                    err,
    output logic [CNT_W-1:0]        steps
);

    localparam int ADDR_W = STATE_W + IN_W;
    localparam int DATA_W = STATE_W + OUT_W;

    logic [STATE_W-1:0] state_q, state_d;
    logic [OUT_W-1:0]   saida_q, saida_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               err_q,   err_d;

    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_vld;
    logic [DATA_W-1:0]  rd_dat;
    logic [STATE_W-1:0] rd_next;
    logic [OUT_W-1:0]   rd_out;

    // Symbol in the MSBs so each symbol owns a contiguous block of states.
    assign rd_addr           = {a, state_q};
    assign {rd_next, rd_out} = rd_dat;

    fsm_table_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdat_i  ({prog_next, prog_out}),
        .raddr_i (rd_addr),
        .rvld_o  (rd_vld),
        .rdat_o  (rd_dat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            saida_q <= RESET_OUT;
            steps_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            saida_q <= saida_d;
            steps_q <= steps_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. A concurrent table write blocks the step, which also
    // guarantees a freshly written entry is never consumed in its write cycle.
    always_comb begin
        state_d = state_q;
        saida_d = saida_q;
        steps_d = steps_q;
        err_d   = err_q;
        if (en && !prog_we) begin
            if (rd_vld) begin
                state_d = rd_next;
                saida_d = rd_out;
                if (steps_q != {CNT_W{1'b1}}) begin
                    steps_d = steps_q + CNT_W'(1);
                end
            end else begin
                // Miss: recover to the reset point and latch the error; count holds.
                state_d = RESET_STATE;
                saida_d = RESET_OUT;
                err_d   = 1'b1;
            end
        end
    end

    // Output logic: straight from registers.
    always_comb begin
        state = state_q;
        saida = saida_q;
        steps = steps_q;
        err   = err_q;
    end

endmodule

// File: tb/tb_fsm_table.sv
module tb_fsm_table;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, a, en, prog_we;
    logic [3:0] prog_addr;
    logic [2:0] prog_next, prog_out;

    logic [2:0] saida, state, saida2, state2;
    logic       err, err2;
    logic [7:0] steps;
    logic [1:0] steps2;

    int n_total = 0;
    int n_pass  = 0;

    fsm_table u_dut (
        .clk(clk), .reset(reset), .a(a), .en(en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_next(prog_next), .prog_out(prog_out),
        .saida(saida), .state(state), .err(err), .steps(steps)
    );

    fsm_table #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .a(a), .en(en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_next(prog_next), .prog_out(prog_out),
        .saida(saida2), .state(state2), .err(err2), .steps(steps2)
    );

    typedef struct {
        logic       rst, en, we, a;
        logic [3:0] addr;
        logic [2:0] pn, po;
        logic [2:0] es, eo;
        logic       ee;
        int         est;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(logic rst, logic e, logic we, logic aa, int addr,
                               int pn, int po, int es, int eo, logic ee, int est);
        vec_t v;
        v.rst = rst; v.en = e; v.we = we; v.a = aa;
        v.addr = 4'(addr); v.pn = 3'(pn); v.po = 3'(po);
        v.es = 3'(es); v.eo = 3'(eo); v.ee = ee; v.est = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: table as plain arrays, indexed by symbol*8 + state.
    bit   m_vld [16];
    int   m_nxt [16];
    int   m_out [16];
    int   m_state, m_saida, m_steps;
    bit   m_err;

    initial begin
        int pa [10] = '{2, 10, 6, 14, 4, 12, 7, 15, 1, 9};
        int pn [10] = '{4,  4, 7,  7, 1,  6, 4,  2, 6, 6};
        int seq0 [6] = '{4, 1, 6, 7, 4, 1};
        int seq1 [6] = '{6, 7, 2, 4, 6, 7};

        reset = 1'b0; a = 1'b0; en = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_next = '0; prog_out = '0;

        // ---- directed vector table ----
        vecs.push_back(V(1,0,0,0, 0,0,0, 2,2,0,0));
        for (int i = 0; i < 10; i++) vecs.push_back(V(0,0,1,0, pa[i],pn[i],pn[i], 2,2,0,0));
        for (int i = 0; i < 6; i++)  vecs.push_back(V(0,1,0,0, 0,0,0, seq0[i],seq0[i],0,i+1));
        for (int i = 0; i < 6; i++)  vecs.push_back(V(0,1,0,1, 0,0,0, seq1[i],seq1[i],0,i+7));
        // write and step together at state 7: write wins, entry used next step
        vecs.push_back(V(0,1,1,0, 7,1,5, 7,7,0,12));
        vecs.push_back(V(0,1,0,0, 0,0,0, 1,5,0,13));
        vecs.push_back(V(0,1,0,1, 0,0,0, 6,6,0,14));
        vecs.push_back(V(0,1,0,1, 0,0,0, 7,7,0,15));
        vecs.push_back(V(0,0,0,1, 0,0,0, 7,7,0,15));
        // reset mid-run beats a concurrent write and step
        vecs.push_back(V(1,1,1,0, 2,5,5, 2,2,0,0));
        vecs.push_back(V(0,1,0,0, 0,0,0, 2,2,1,0));
        vecs.push_back(V(0,1,0,0, 0,0,0, 2,2,1,0));
        vecs.push_back(V(1,0,0,0, 0,0,0, 2,2,0,0));
        // state 1 left unprogrammed
        vecs.push_back(V(0,0,1,0, 2,4,4, 2,2,0,0));
        vecs.push_back(V(0,0,1,0, 4,1,1, 2,2,0,0));
        vecs.push_back(V(0,1,0,0, 0,0,0, 4,4,0,1));
        vecs.push_back(V(0,1,0,0, 0,0,0, 1,1,0,2));
        vecs.push_back(V(0,1,0,0, 0,0,0, 2,2,1,2));
        vecs.push_back(V(0,1,0,0, 0,0,0, 4,4,1,3));
        vecs.push_back(V(0,0,0,0, 0,0,0, 4,4,1,3));
        vecs.push_back(V(1,0,0,0, 0,0,0, 2,2,0,0));
        vecs.push_back(V(0,1,0,0, 0,0,0, 2,2,1,0));

        foreach (vecs[i]) begin
            reset = vecs[i].rst; en = vecs[i].en; prog_we = vecs[i].we; a = vecs[i].a;
            prog_addr = vecs[i].addr; prog_next = vecs[i].pn; prog_out = vecs[i].po;
            step();
            chk($sformatf("v%0d.state", i),  32'(state),  32'(vecs[i].es));
            chk($sformatf("v%0d.saida", i),  32'(saida),  32'(vecs[i].eo));
            chk($sformatf("v%0d.err", i),    32'(err),    32'(vecs[i].ee));
            chk($sformatf("v%0d.steps", i),  32'(steps),  32'(sat(vecs[i].est, 255)));
            chk($sformatf("v%0d.steps2", i), 32'(steps2), 32'(sat(vecs[i].est, 3)));
        end

        // ---- randomized run against the reference model ----
        for (int c = 0; c < 600; c++) begin
            reset     = (c == 0) || ($urandom_range(0, 59) == 0);
            en        = 1'($urandom_range(0, 3) != 0);
            prog_we   = ($urandom_range(0, 3) == 0);
            a         = 1'($urandom_range(0, 1));
            prog_addr = 4'($urandom_range(0, 15));
            prog_next = 3'($urandom_range(0, 7));
            prog_out  = 3'($urandom_range(0, 7));

            if (reset) begin
                for (int k = 0; k < 16; k++) m_vld[k] = 1'b0;
                m_state = 2; m_saida = 2; m_err = 1'b0; m_steps = 0;
            end else if (prog_we) begin
                m_vld[prog_addr] = 1'b1;
                m_nxt[prog_addr] = int'(prog_next);
                m_out[prog_addr] = int'(prog_out);
            end else if (en) begin
                int idx;
                idx = int'(a) * 8 + m_state;
                if (m_vld[idx]) begin
                    m_state = m_nxt[idx]; m_saida = m_out[idx]; m_steps++;
                end else begin
                    m_state = 2; m_saida = 2; m_err = 1'b1;
                end
            end

            step();
            chk($sformatf("rand%0d", c),
                {7'd0, state, saida, err, steps, steps2, state2, saida2, err2},
                {7'd0, 3'(m_state), 3'(m_saida), m_err, 8'(sat(m_steps, 255)),
                 2'(sat(m_steps, 3)), 3'(m_state), 3'(m_saida), m_err});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
